// File: rtl/i2c_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_arbiter_if
// Description : Bundles the two requester ports and the I2C master handshake
//               of i2c_master_arbiter.
//               master modport : the arbiter (drives grants, strobes, m_*)
//               slave  modport : the environment (requesters + I2C master core)
//               Requester n (0/1): reqN, rwN, addrN, lenN, wdataN in;
//                                  grantN, wtakeN, rvalidN, doneN, errN out.
//               Shared: rdata out.
//               Master side: m_start, m_rw, m_addr, m_len, m_datasend,
//                            m_sended, m_received out; m_ready, m_send,
//                            m_receive, m_datareceive, m_nack in.
// Revision    : 1.0 - initial release
// ============================================================================
interface i2c_master_arbiter_if;
    logic       req0, req1;
    logic       rw0, rw1;
    logic [6:0] addr0, addr1;
    logic [3:0] len0, len1;
    logic [7:0] wdata0, wdata1;
    logic       grant0, grant1;
    logic       wtake0, wtake1;
    logic       rvalid0, rvalid1;
    logic       done0, done1;
    logic       err0, err1;
    logic [7:0] rdata;

    logic       m_start;
    logic       m_rw;
    logic [6:0] m_addr;
    logic [3:0] m_len;
    logic [7:0] m_datasend;
    logic       m_sended;
    logic       m_received;
    logic       m_ready;
    logic       m_send;
    logic       m_receive;
    logic [7:0] m_datareceive;
    logic       m_nack;

    modport master (
        input  req0, req1, rw0, rw1, addr0, addr1, len0, len1, wdata0, wdata1,
        output grant0, grant1, wtake0, wtake1, rvalid0, rvalid1,
        output done0, done1, err0, err1, rdata,
        output m_start, m_rw, m_addr, m_len, m_datasend, m_sended, m_received,
        input  m_ready, m_send, m_receive, m_datareceive, m_nack
    );

    modport slave (
        output req0, req1, rw0, rw1, addr0, addr1, len0, len1, wdata0, wdata1,
        input  grant0, grant1, wtake0, wtake1, rvalid0, rvalid1,
        input  done0, done1, err0, err1, rdata,
        input  m_start, m_rw, m_addr, m_len, m_datasend, m_sended, m_received,
        output m_ready, m_send, m_receive, m_datareceive, m_nack
    );
endinterface
`default_nettype wire

// File: rtl/i2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_master_arbiter
// Description : Shares one I2C master core between two requesters with
//               round-robin arbitration, per-byte write/read handshakes,
//               NACK abort and a no-progress timeout.
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-low
//               bus   - i2c_master_arbiter_if.master (requesters + master core)
// Parameters  : TIMEOUT - cycles without handshake progress before abort
//                         (counted from the LAUNCH cycle), must be >= 2
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_master_arbiter #(
    parameter int TIMEOUT = 50000
) (
    input  wire logic             clk,
    input  wire logic             reset,
    i2c_master_arbiter_if.master  bus
);

    localparam int                 c_TMR_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_ONE  = c_TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_XFER   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t             r_state, w_state_d;
    logic               r_owner, w_owner_d;
    logic               r_last, w_last_d;
    logic [1:0]         r_grant, w_grant_d;
    logic [1:0]         r_wtake, w_wtake_d;
    logic [1:0]         r_rvalid, w_rvalid_d;
    logic [1:0]         r_done, w_done_d;
    logic [1:0]         r_err, w_err_d;
    logic [7:0]         r_rdata, w_rdata_d;
    logic               r_m_start, w_m_start_d;
    logic               r_m_rw, w_m_rw_d;
    logic [6:0]         r_m_addr, w_m_addr_d;
    logic [3:0]         r_m_len, w_m_len_d;
    logic [7:0]         r_m_datasend, w_m_datasend_d;
    logic               r_m_sended, w_m_sended_d;
    logic               r_m_received, w_m_received_d;
    logic [3:0]         r_count, w_count_d;
    logic [c_TMR_W-1:0] r_timer, w_timer_d;

    // Requester selection: on a tie the one not served last wins.
    logic       w_sel;
    logic [3:0] w_len_sel;
    logic [7:0] w_wdata;
    assign w_sel     = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_len_sel = r_owner ? bus.len1 : bus.len0;
    assign w_wdata   = r_owner ? bus.wdata1 : bus.wdata0;

    always_comb begin
        w_state_d      = r_state;
        w_owner_d      = r_owner;
        w_last_d       = r_last;
        w_grant_d      = r_grant;
        w_wtake_d      = 2'b00;
        w_rvalid_d     = 2'b00;
        w_done_d       = 2'b00;
        w_err_d        = 2'b00;
        w_rdata_d      = r_rdata;
        w_m_start_d    = 1'b0;
        w_m_rw_d       = r_m_rw;
        w_m_addr_d     = r_m_addr;
        w_m_len_d      = r_m_len;
        w_m_datasend_d = r_m_datasend;
        w_m_sended_d   = 1'b0;
        w_m_received_d = 1'b0;
        w_count_d      = r_count;
        w_timer_d      = r_timer;

        case (r_state)
            S_IDLE: begin
                // Zero here so the LAUNCH cycle is the first one counted.
                w_timer_d = '0;
                if (bus.m_ready && (bus.req0 || bus.req1)) begin
                    w_owner_d = w_sel;
                    w_grant_d = w_sel ? 2'b10 : 2'b01;
                    w_state_d = S_LAUNCH;
                end
            end

            S_LAUNCH: begin
                w_m_rw_d    = r_owner ? bus.rw1 : bus.rw0;
                w_m_addr_d  = r_owner ? bus.addr1 : bus.addr0;
                w_m_len_d   = (w_len_sel == 4'd0) ? 4'd1 : w_len_sel;
                w_m_start_d = 1'b1;
                w_count_d   = 4'd0;
                w_timer_d   = r_timer + c_TMR_ONE;
                w_state_d   = S_XFER;
            end

            S_XFER: begin
                w_timer_d = r_timer + c_TMR_ONE;
                if (bus.m_nack || (r_timer == c_TMR_LAST)) begin
                    w_err_d[r_owner]  = 1'b1;
                    w_done_d[r_owner] = 1'b1;
                    w_last_d          = r_owner;
                    w_state_d         = S_FINISH;
                end else if (r_count == r_m_len) begin
                    // All bytes moved; any further handshake is dropped.
                    if (bus.m_ready) begin
                        w_done_d[r_owner] = 1'b1;
                        w_last_d          = r_owner;
                        w_state_d         = S_FINISH;
                    end
                end else if (!r_m_rw && bus.m_send && !r_m_sended) begin
                    w_m_datasend_d     = w_wdata;
                    w_m_sended_d       = 1'b1;
                    w_wtake_d[r_owner] = 1'b1;
                    w_count_d          = r_count + 4'd1;
                    w_timer_d          = '0;
                end else if (r_m_rw && bus.m_receive && !r_m_received) begin
                    w_rdata_d           = bus.m_datareceive;
                    w_m_received_d      = 1'b1;
                    w_rvalid_d[r_owner] = 1'b1;
                    w_count_d           = r_count + 4'd1;
                    w_timer_d           = '0;
                end
            end

            S_FINISH: begin
                // doneN is high in this cycle; the grant drops right after.
                w_grant_d = 2'b00;
                w_timer_d = '0;
                w_state_d = S_IDLE;
            end

            default: begin
                w_grant_d = 2'b00;
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last       <= 1'b1;
            r_grant      <= 2'b00;
            r_wtake      <= 2'b00;
            r_rvalid     <= 2'b00;
            r_done       <= 2'b00;
            r_err        <= 2'b00;
            r_rdata      <= 8'h00;
            r_m_start    <= 1'b0;
            r_m_rw       <= 1'b0;
            r_m_addr     <= 7'h00;
            r_m_len      <= 4'h0;
            r_m_datasend <= 8'h00;
            r_m_sended   <= 1'b0;
            r_m_received <= 1'b0;
            r_count      <= 4'd0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_state_d;
            r_owner      <= w_owner_d;
            r_last       <= w_last_d;
            r_grant      <= w_grant_d;
            r_wtake      <= w_wtake_d;
            r_rvalid     <= w_rvalid_d;
            r_done       <= w_done_d;
            r_err        <= w_err_d;
            r_rdata      <= w_rdata_d;
            r_m_start    <= w_m_start_d;
            r_m_rw       <= w_m_rw_d;
            r_m_addr     <= w_m_addr_d;
            r_m_len      <= w_m_len_d;
            r_m_datasend <= w_m_datasend_d;
            r_m_sended   <= w_m_sended_d;
            r_m_received <= w_m_received_d;
            r_count      <= w_count_d;
            r_timer      <= w_timer_d;
        end
    end

    assign bus.grant0     = r_grant[0];
    assign bus.grant1     = r_grant[1];
    assign bus.wtake0     = r_wtake[0];
    assign bus.wtake1     = r_wtake[1];
    assign bus.rvalid0    = r_rvalid[0];
    assign bus.rvalid1    = r_rvalid[1];
    assign bus.done0      = r_done[0];
    assign bus.done1      = r_done[1];
    assign bus.err0       = r_err[0];
    assign bus.err1       = r_err[1];
    assign bus.rdata      = r_rdata;
    assign bus.m_start    = r_m_start;
    assign bus.m_rw       = r_m_rw;
    assign bus.m_addr     = r_m_addr;
    assign bus.m_len      = r_m_len;
    assign bus.m_datasend = r_m_datasend;
    assign bus.m_sended   = r_m_sended;
    assign bus.m_received = r_m_received;

endmodule
`default_nettype wire
